// File: rtl/core_issue_controller_pkg.sv
// rtl/core_issue_controller_pkg.sv - shared types and constants for the instruction issue controller
//
// Contents:
//   state_t  issue FSM encoding (IDLE=0, ISSUE=1, WAIT=2)
//   CNT_W    width of the issue/retire/timeout performance counters
//   INSTR_W  width of one RISC-V instruction word
package core_issue_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam int CNT_W   = 32;
   localparam int INSTR_W = 32;

endpackage

// File: rtl/core_issue_controller_issue_fifo.sv
// rtl/core_issue_controller_issue_fifo.sv - circular instruction buffer between host and issue FSM
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   flush             synchronous clear; also suppresses any push/pop in that cycle
//   push, push_data   write request and word (ignored when full)
//   pop, pop_data     read request and head word (pop_data is valid whenever !empty)
//   full, empty       occupancy flags
//   level             occupied entries, 0..DEPTH
module issue_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Pointers carry one extra lap bit so full and empty are distinguishable.
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign level     = r_wr_ptr - r_rd_ptr;
   assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign w_push_ok = push && !full && !flush;
   assign w_pop_ok  = pop && !empty && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only read between the pointers.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/core_issue_controller.sv
// rtl/core_issue_controller.sv - buffers host instructions and issues them one at a time to the core
//
// Build option: ISSUE_TIMEOUT_EN enables the WAIT-state watchdog; without it WAIT
// exits only on coreComplete and timeoutCount is tied to 0.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   flush                       synchronous clear of FIFO and FSM (counters kept)
//   inInstruction/inValid       host push; accepted when inValid && inReady
//   inReady                     FIFO not full
//   coreInstruction/coreValid   issued word, coreValid high for one cycle per word
//   coreComplete                core retire strobe, honoured only in WAIT
//   busy                        FSM not idle or FIFO non-empty
//   fifoLevel                   occupied FIFO entries
//   issuedCount/retiredCount/timeoutCount  wrapping performance counters
module core_issue_controller
   import core_issue_controller_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [INSTR_W-1:0]       inInstruction,
   input  logic                     inValid,
   output logic                     inReady,
   output logic [INSTR_W-1:0]       coreInstruction,
   output logic                     coreValid,
   input  logic                     coreComplete,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifoLevel,
   output logic [CNT_W-1:0]         issuedCount,
   output logic [CNT_W-1:0]         retiredCount,
   output logic [CNT_W-1:0]         timeoutCount
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t              r_state;
   logic [INSTR_W-1:0]  r_hold;
   logic                r_core_valid;
   logic [CNT_W-1:0]    r_issued;
   logic [CNT_W-1:0]    r_retired;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic [INSTR_W-1:0]  w_head;

`ifdef ISSUE_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]       r_timer;
   logic [CNT_W-1:0]    r_timeout;
`endif

   // The FSM takes the head word only from IDLE; flush wins over the pop.
   assign w_pop = (r_state == ST_IDLE) && !w_empty && !flush;

   issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (inValid),
      .push_data (inInstruction),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifoLevel)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_hold       <= '0;
         r_core_valid <= 1'b0;
         r_issued     <= '0;
         r_retired    <= '0;
`ifdef ISSUE_TIMEOUT_EN
         r_timer      <= '0;
         r_timeout    <= '0;
`endif
      end else if (flush) begin
         // An in-flight word is dropped without touching any counter.
         r_state      <= ST_IDLE;
         r_core_valid <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
         r_timer      <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_hold       <= w_head;
                  r_core_valid <= 1'b1;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_core_valid <= 1'b0;
               r_issued     <= r_issued + 1'b1;
               r_state      <= ST_WAIT;
`ifdef ISSUE_TIMEOUT_EN
               r_timer      <= '0;
`endif
            end
            ST_WAIT: begin
               if (coreComplete) begin
                  r_retired <= r_retired + 1'b1;
                  r_state   <= ST_IDLE;
`ifdef ISSUE_TIMEOUT_EN
               end else if (r_timer == TIMER_LAST) begin
                  r_timeout <= r_timeout + 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_timer   <= r_timer + 1'b1;
`endif
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_core_valid <= 1'b0;
            end
         endcase
      end
   end

   assign inReady         = !w_full;
   assign coreInstruction = r_hold;
   assign coreValid       = r_core_valid;
   assign busy            = (r_state != ST_IDLE) || !w_empty;
   assign issuedCount     = r_issued;
   assign retiredCount    = r_retired;
`ifdef ISSUE_TIMEOUT_EN
   assign timeoutCount    = r_timeout;
`else
   assign timeoutCount    = '0;
`endif

endmodule

// File: tb/tb_core_issue_controller.sv
// tb/tb_core_issue_controller.sv - scoreboard bench for core_issue_controller
module tb_core_issue_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] inInstruction = '0;
   logic        inValid = 1'b0;
   logic        coreComplete = 1'b0;
   logic        inReady;
   logic [31:0] coreInstruction;
   logic        coreValid;
   logic        busy;
   logic [3:0]  fifoLevel;
   logic [31:0] issuedCount;
   logic [31:0] retiredCount;
   logic [31:0] timeoutCount;

`ifdef ISSUE_TIMEOUT_EN
   localparam int EXP_TO = 1;
`else
   localparam int EXP_TO = 0;
`endif

   core_issue_controller u_dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .inInstruction   (inInstruction),
      .inValid         (inValid),
      .inReady         (inReady),
      .coreInstruction (coreInstruction),
      .coreValid       (coreValid),
      .coreComplete    (coreComplete),
      .busy            (busy),
      .fifoLevel       (fifoLevel),
      .issuedCount     (issuedCount),
      .retiredCount    (retiredCount),
      .timeoutCount    (timeoutCount)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   bit          auto_cpl = 1'b0;
   bit          pend = 1'b0;
   bit          gap_chk = 1'b0;
   bit          have_last = 1'b0;
   int          last_cyc = 0;

   logic [31:0] burst_w [9] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213,
                                32'h00500293, 32'h00600313, 32'h00700393, 32'h00800413,
                                32'h00900493};
   logic [31:0] pre_w [3] = '{32'h001080B3, 32'h00210133, 32'h003181B3};
   logic [31:0] flow_w [8] = '{32'h00A00513, 32'h00B00593, 32'h00C00613, 32'h00D00693,
                               32'h00E00713, 32'h00F00793, 32'h01000813, 32'h01100893};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_inReady"},  inReady, 1);
      check({tag, "_coreValid"}, coreValid, 0);
      check({tag, "_coreInstr"}, coreInstruction, 0);
      check({tag, "_busy"},     busy, 0);
      check({tag, "_level"},    fifoLevel, 0);
      check({tag, "_issued"},   issuedCount, 0);
      check({tag, "_retired"},  retiredCount, 0);
      check({tag, "_timeout"},  timeoutCount, 0);
   endtask

   // Monitor + core model: compares every issued word against the scoreboard,
   // and when auto_cpl is set answers each issue with a complete one cycle later.
   always @(negedge clk) begin
      if (coreValid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_unexpected: got 0x%08h expected no issue", coreInstruction);
         end else begin
            check("issue_word", coreInstruction, exp_q.pop_front());
         end
         if (gap_chk) begin
            if (have_last) check("issue_gap", cyc - last_cyc, 3);
            have_last = 1'b1;
            last_cyc  = cyc;
         end
      end
      if (auto_cpl) begin
         coreComplete = pend;
         pend         = coreValid;
      end
   end

   initial begin
      // Reset state
      step(3);
      check_reset_values("reset");
      reset = 1'b1;
      step(1);

      // Single word, latency and retire
      auto_cpl = 1'b1;
      inInstruction = 32'h002081B3;
      inValid = 1'b1;
      exp_q.push_back(32'h002081B3);
      @(negedge clk);
      inValid = 1'b0;
      check("single_level", fifoLevel, 1);
      check("single_valid_early", coreValid, 0);
      @(negedge clk);
      check("single_valid", coreValid, 1);
      @(negedge clk);
      check("single_valid_one_cycle", coreValid, 0);
      @(negedge clk);
      check("single_retired", retiredCount, 1);
      check("single_issued", issuedCount, 1);
      check("single_busy", busy, 0);
      step(2);

      // Burst: blocker holds the FSM in WAIT while the FIFO fills
      auto_cpl = 1'b0;
      pend = 1'b0;
      coreComplete = 1'b0;
      inInstruction = 32'h40208233;
      inValid = 1'b1;
      exp_q.push_back(32'h40208233);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 8) begin
            check("burst_inready_full", inReady, 0);
            check("burst_level_full", fifoLevel, 8);
         end else begin
            check("burst_inready", inReady, 1);
            exp_q.push_back(burst_w[i]);
         end
         inInstruction = burst_w[i];
         inValid = 1'b1;
      end
      @(negedge clk);
      inValid = 1'b0;
      check("burst_drop_level", fifoLevel, 8);
      coreComplete = 1'b1;
      @(negedge clk);
      coreComplete = 1'b0;
      pend = 1'b0;
      have_last = 1'b0;
      gap_chk = 1'b1;
      auto_cpl = 1'b1;
      step(30);
      gap_chk = 1'b0;
      check("burst_issued", issuedCount, 10);
      check("burst_retired", retiredCount, 10);
      check("burst_level_empty", fifoLevel, 0);
      check("burst_busy", busy, 0);
      check("burst_queue_drained", exp_q.size(), 0);

      // Complete outside WAIT is ignored
      auto_cpl = 1'b0;
      coreComplete = 1'b1;
      @(negedge clk);
      coreComplete = 1'b0;
      @(negedge clk);
      check("idle_complete_ignored", retiredCount, 10);

      // Word never completed: watchdog or indefinite stall
      inInstruction = 32'h0000006F;
      inValid = 1'b1;
      exp_q.push_back(32'h0000006F);
      @(negedge clk);
      inValid = 1'b0;
`ifdef ISSUE_TIMEOUT_EN
      step(17);
      check("timeout_busy_before", busy, 1);
      @(negedge clk);
      check("timeout_busy_after", busy, 0);
      check("timeout_count", timeoutCount, 1);
`else
      step(40);
      check("stall_busy", busy, 1);
      check("stall_timeout_zero", timeoutCount, 0);
`endif
      flush = 1'b1;
      inInstruction = 32'hDEADBEEF;
      inValid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      inValid = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_level", fifoLevel, 0);
      check("flush_valid", coreValid, 0);
      step(3);
      check("flush_push_dropped", fifoLevel, 0);
      check("flush_issued", issuedCount, 11);
      check("flush_retired", retiredCount, 10);

      // Simultaneous push/pop at level 3
      inInstruction = 32'h00308133;
      inValid = 1'b1;
      exp_q.push_back(32'h00308133);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         inInstruction = pre_w[i];
         exp_q.push_back(pre_w[i]);
      end
      @(negedge clk);
      inValid = 1'b0;
      check("flow_prefill_level", fifoLevel, 3);
      coreComplete = 1'b1;
      @(negedge clk);
      coreComplete = 1'b0;
      pend = 1'b0;
      auto_cpl = 1'b1;
      for (int k = 0; k < 8; k++) begin
         inInstruction = flow_w[k];
         inValid = 1'b1;
         exp_q.push_back(flow_w[k]);
         @(negedge clk);
         inValid = 1'b0;
         check("flow_level_a", fifoLevel, 3);
         @(negedge clk);
         check("flow_level_b", fifoLevel, 3);
         @(negedge clk);
         check("flow_level_c", fifoLevel, 3);
      end
      step(20);
      check("flow_issued", issuedCount, 23);
      check("flow_retired", retiredCount, 22);
      check("flow_timeout", timeoutCount, EXP_TO);
      check("flow_level_empty", fifoLevel, 0);
      check("flow_queue_drained", exp_q.size(), 0);

      // Asynchronous reset while waiting on the core
      auto_cpl = 1'b0;
      pend = 1'b0;
      inInstruction = 32'h00A50533;
      inValid = 1'b1;
      exp_q.push_back(32'h00A50533);
      @(negedge clk);
      inValid = 1'b0;
      step(2);
      check("midwait_busy", busy, 1);
      #2 reset = 1'b0;
      #1 check_reset_values("async_reset");
      @(negedge clk);
      reset = 1'b1;
      step(2);
      check_reset_values("post_reset");
      check("final_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
